// File: rtl/hdc_pkg.sv
// Shared definitions for the HDC spam datapath: default sizes, the label type,
// the n-gram feeder state encoding and a length clamp helper.
package hdc_pkg;

  localparam int MAX_LENGTH_DEF = 200;
  localparam int NGRAM_DEF      = 3;
  localparam int CNT_W_DEF      = 16;

  typedef logic [1:0] label_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_STREAM,
    ST_WAIT_CLASS,
    ST_DONE
  } feeder_state_t;

  function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/ngram_window.sv
// NGRAM-byte sliding window: newest byte enters at [7:0], the oldest byte sits
// in the top byte lane. Clear has priority over shift.
module ngram_window
  import hdc_pkg::*;
#(
  parameter int NGRAM = NGRAM_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic [7:0]         byte_i,
  output logic [NGRAM*8-1:0] gram_o
);

  logic [NGRAM*8-1:0] win_q, win_d;

  // NOTE: every path through always_comb starts from a default so no latch is inferred.
  always_comb begin
    win_d = win_q;
    if (clr_i) begin
      win_d = '0;
    end else if (shift_i) begin
      win_d = {win_q[NGRAM*8-9:0], byte_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign gram_o = win_q;

endmodule

// File: rtl/msg_ngram_feeder.sv
// Captures one message, streams its overlapping n-grams to the HDC encoder,
// scores the encoder's decision against the label and pulses compute_done.
module msg_ngram_feeder
  import hdc_pkg::*;
#(
  parameter int MAX_LENGTH = MAX_LENGTH_DEF,
  parameter int NGRAM      = NGRAM_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MAX_LENGTH*8-1:0] msg,
  input  logic                    msg_valid,
  input  logic [7:0]              length,
  input  label_t                  label,
  output logic [NGRAM*8-1:0]      gram_data,
  output logic                    gram_valid,
  input  logic                    gram_ready,
  output logic                    gram_last,
  input  logic                    class_valid,
  input  label_t                  class_label,
  output logic                    compute_done,
  output logic                    busy,
  output logic [CNT_W-1:0]        total_cnt,
  output logic [CNT_W-1:0]        correct_cnt
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LENGTH);
  localparam logic [7:0] NGRAM_B   = 8'(NGRAM);

  feeder_state_t           state_q;
  logic [MAX_LENGTH*8-1:0] msg_q;
  logic [7:0]              eff_len_q, eff_len_d;
  label_t                  label_q;
  logic [7:0]              idx_q;
  logic                    gram_valid_q;
  logic                    busy_q;
  logic                    compute_done_q;
  logic [CNT_W-1:0]        total_q;
  logic [CNT_W-1:0]        correct_q;

  logic [7:0] cur_byte;
  logic       last_w;
  logic       xfer;
  logic       win_clr;
  logic       win_shift;

  assign eff_len_d = clamp_len(length, MAX_LEN_B);
  assign last_w    = gram_valid_q && (idx_q == eff_len_q);
  assign xfer      = gram_valid_q && gram_ready;
  assign win_clr   = (state_q == ST_IDLE) && msg_valid;
  assign win_shift = (state_q == ST_PRIME) || (xfer && !last_w);

  // idx_q can reach eff_len, one past the last byte; out-of-range selects read as zero.
  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < MAX_LENGTH; i++) begin
      if (idx_q == 8'(i)) cur_byte = msg_q[i*8 +: 8];
    end
  end

  ngram_window #(
    .NGRAM(NGRAM)
  ) u_window (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (win_clr),
    .shift_i(win_shift),
    .byte_i (cur_byte),
    .gram_o (gram_data)
  );

  // NOTE: all state below is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      // NOTE: the wide message register is cleared too, so no stale bytes survive an abort.
      msg_q          <= '0;
      eff_len_q      <= '0;
      label_q        <= '0;
      idx_q          <= '0;
      gram_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      compute_done_q <= 1'b0;
      total_q        <= '0;
      correct_q      <= '0;
    end else begin
      compute_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (msg_valid) begin
            msg_q     <= msg;
            eff_len_q <= eff_len_d;
            label_q   <= label;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            if (eff_len_d < NGRAM_B) begin
              state_q        <= ST_DONE;
              compute_done_q <= 1'b1;
            end else begin
              state_q <= ST_PRIME;
            end
          end
        end

        ST_PRIME: begin
          idx_q <= idx_q + 8'd1;
          if (idx_q == NGRAM_B - 8'd1) begin
            state_q      <= ST_STREAM;
            gram_valid_q <= 1'b1;
          end
        end

        ST_STREAM: begin
          if (xfer) begin
            if (last_w) begin
              state_q      <= ST_WAIT_CLASS;
              gram_valid_q <= 1'b0;
            end else begin
              idx_q <= idx_q + 8'd1;
            end
          end
        end

        ST_WAIT_CLASS: begin
          if (class_valid) begin
            // Counters saturate rather than wrap.
            if (total_q != '1) total_q <= total_q + CNT_W'(1);
            if ((class_label == label_q) && (correct_q != '1)) correct_q <= correct_q + CNT_W'(1);
            state_q        <= ST_DONE;
            compute_done_q <= 1'b1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q      <= ST_IDLE;
          gram_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign gram_valid   = gram_valid_q;
  assign gram_last    = last_w;
  assign compute_done = compute_done_q;
  assign busy         = busy_q;
  assign total_cnt    = total_q;
  assign correct_cnt  = correct_q;

endmodule

// File: tb/tb_msg_ngram_feeder.sv
// Scoreboard bench for msg_ngram_feeder: expected grams are queued when a message
// is sent and popped as the encoder-side handshake accepts each gram.
module tb_msg_ngram_feeder;

  localparam int MAX_LENGTH = 200;
  localparam int NGRAM      = 3;
  localparam int CNT_W      = 3;
  localparam int W          = NGRAM * 8;

  typedef logic [W:0] word_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [MAX_LENGTH*8-1:0] msg;
  logic                    msg_valid;
  logic [7:0]              length;
  logic [1:0]              label;
  logic [W-1:0]            gram_data;
  logic                    gram_valid;
  logic                    gram_ready;
  logic                    gram_last;
  logic                    class_valid;
  logic [1:0]              class_label;
  logic                    compute_done;
  logic                    busy;
  logic [CNT_W-1:0]        total_cnt;
  logic [CNT_W-1:0]        correct_cnt;

  always #5 clk = ~clk;

  msg_ngram_feeder #(
    .MAX_LENGTH(MAX_LENGTH),
    .NGRAM     (NGRAM),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .msg         (msg),
    .msg_valid   (msg_valid),
    .length      (length),
    .label       (label),
    .gram_data   (gram_data),
    .gram_valid  (gram_valid),
    .gram_ready  (gram_ready),
    .gram_last   (gram_last),
    .class_valid (class_valid),
    .class_label (class_label),
    .compute_done(compute_done),
    .busy        (busy),
    .total_cnt   (total_cnt),
    .correct_cnt (correct_cnt)
  );

  int    cyc = 0;
  int    cmp_cnt = 0;
  int    err_cnt = 0;
  word_t exp_q[$];
  int    xfer_cnt = 0;
  int    gv_cnt = 0;
  int    done_cnt = 0;
  int    done_cyc = -1;
  int    first_xfer_cyc = -1;
  int    last_xfer_cyc = -1;
  int    stall_viol = 0;
  bit    first_seen = 1'b0;
  bit    prev_stall = 1'b0;
  word_t prev_word;
  word_t last_word;
  word_t mon_w;
  word_t mon_e;

  always @(posedge clk) cyc++;

  // Monitor: sampled on the falling edge, compares every accepted gram with the queue.
  always @(negedge clk) begin
    if (gram_valid) gv_cnt++;
    if (compute_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_stall && gram_valid && ({gram_last, gram_data} !== prev_word)) stall_viol++;
    prev_stall = gram_valid && !gram_ready;
    prev_word  = {gram_last, gram_data};
    if (gram_valid && gram_ready) begin
      mon_w = {gram_last, gram_data};
      cmp_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL gram_unexpected: got %h, none expected", mon_w);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_w !== mon_e) begin
          err_cnt++;
          $display("FAIL gram_seq: got %h, expected %h", mon_w, mon_e);
        end
      end
      if (!first_seen) begin
        first_xfer_cyc = cyc;
        first_seen     = 1'b1;
      end
      last_xfer_cyc = cyc;
      last_word     = mon_w;
      xfer_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    exp_q.delete();
    xfer_cnt   = 0;
    gv_cnt     = 0;
    stall_viol = 0;
    first_seen = 1'b0;
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    msg         = '0;
    msg_valid   = 1'b0;
    length      = '0;
    label       = '0;
    gram_ready  = 1'b0;
    class_valid = 1'b0;
    class_label = '0;
    repeat (2) tick();
    rst = 1'b0;
    clear_stats();
  endtask

  function automatic logic [MAX_LENGTH*8-1:0] str2msg(input string s);
    logic [MAX_LENGTH*8-1:0] m;
    m = '0;
    for (int i = 0; i < s.len(); i++) m[i*8 +: 8] = s[i];
    return m;
  endfunction

  // Drives a one-cycle msg_valid and queues the grams the message must produce.
  task automatic send_msg(input logic [MAX_LENGTH*8-1:0] m, input int len,
                          input logic [1:0] lbl, output int t);
    int           eff;
    logic [W-1:0] g;
    eff = (len > MAX_LENGTH) ? MAX_LENGTH : len;
    for (int k = NGRAM - 1; k < eff; k++) begin
      g = '0;
      for (int j = 0; j < NGRAM; j++) g[j*8 +: 8] = m[(k-j)*8 +: 8];
      exp_q.push_back({(k == eff - 1), g});
    end
    msg       = m;
    length    = 8'(len);
    label     = lbl;
    msg_valid = 1'b1;
    t         = cyc;
    tick();
    msg_valid = 1'b0;
  endtask

  task automatic pulse_class(input logic [1:0] lbl, output int tc);
    class_valid = 1'b1;
    class_label = lbl;
    tc          = cyc;
    tick();
    class_valid = 1'b0;
  endtask

  task automatic wait_gv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (gram_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_last(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (gram_valid && gram_last && gram_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    cmp_cnt++; if (gram_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_gram_valid: got %b expected 0", gram_valid); end
    cmp_cnt++; if (gram_last !== 1'b0) begin err_cnt++; $display("FAIL rst_gram_last: got %b expected 0", gram_last); end
    cmp_cnt++; if (gram_data !== '0) begin err_cnt++; $display("FAIL rst_gram_data: got %h expected 0", gram_data); end
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b expected 0", busy); end
    cmp_cnt++; if (compute_done !== 1'b0) begin err_cnt++; $display("FAIL rst_done: got %b expected 0", compute_done); end
    cmp_cnt++; if (total_cnt !== '0) begin err_cnt++; $display("FAIL rst_total: got %0d expected 0", total_cnt); end
    cmp_cnt++; if (correct_cnt !== '0) begin err_cnt++; $display("FAIL rst_correct: got %0d expected 0", correct_cnt); end
  endtask

  task automatic test_basic();
    int t, tc, base;
    bit ok1, ok2;
    apply_reset();
    gram_ready = 1'b1;
    base = done_cnt;
    send_msg(str2msg("hello"), 5, 2'd1, t);
    cmp_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL basic_busy: got %b expected 1", busy); end
    wait_last(ok1);
    repeat (3) tick();
    pulse_class(2'd1, tc);
    wait_done(base, ok2);
    repeat (3) tick();
    cmp_cnt++; if (!ok1 || !ok2) begin err_cnt++; $display("FAIL basic_timeout: got last=%b done=%b expected 1 1", ok1, ok2); end
    cmp_cnt++; if (first_xfer_cyc !== t + 4) begin err_cnt++; $display("FAIL basic_latency: got cycle %0d expected %0d", first_xfer_cyc, t + 4); end
    cmp_cnt++; if (last_xfer_cyc !== t + 6) begin err_cnt++; $display("FAIL basic_last_cycle: got %0d expected %0d", last_xfer_cyc, t + 6); end
    cmp_cnt++; if (xfer_cnt !== 3) begin err_cnt++; $display("FAIL basic_xfers: got %0d expected 3", xfer_cnt); end
    cmp_cnt++; if (done_cyc !== tc + 1) begin err_cnt++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_cyc, tc + 1); end
    cmp_cnt++; if (done_cnt - base !== 1) begin err_cnt++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt - base); end
    cmp_cnt++; if (total_cnt !== 3'd1) begin err_cnt++; $display("FAIL basic_total: got %0d expected 1", total_cnt); end
    cmp_cnt++; if (correct_cnt !== 3'd1) begin err_cnt++; $display("FAIL basic_correct: got %0d expected 1", correct_cnt); end
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL basic_idle: got busy %b expected 0", busy); end
    cmp_cnt++; if (exp_q.size() !== 0) begin err_cnt++; $display("FAIL basic_left: got %0d grams missing expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int t, tc, base;
    bit ok1, ok2;
    bit [0:5] pat;
    apply_reset();
    pat = 6'b001011;
    base = done_cnt;
    send_msg(str2msg("hello"), 5, 2'd1, t);
    wait_gv(ok1);
    for (int i = 0; i < 6; i++) begin
      gram_ready = pat[i];
      tick();
    end
    gram_ready = 1'b0;
    cmp_cnt++; if (gram_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_valid_drop: got %b expected 0", gram_valid); end
    pulse_class(2'd2, tc);
    wait_done(base, ok2);
    tick();
    cmp_cnt++; if (!ok1 || !ok2) begin err_cnt++; $display("FAIL bp_timeout: got valid=%b done=%b expected 1 1", ok1, ok2); end
    cmp_cnt++; if (xfer_cnt !== 3) begin err_cnt++; $display("FAIL bp_xfers: got %0d expected 3", xfer_cnt); end
    cmp_cnt++; if (stall_viol !== 0) begin err_cnt++; $display("FAIL bp_stable: got %0d changes under stall expected 0", stall_viol); end
    cmp_cnt++; if (total_cnt !== 3'd1) begin err_cnt++; $display("FAIL bp_total: got %0d expected 1", total_cnt); end
    cmp_cnt++; if (correct_cnt !== 3'd0) begin err_cnt++; $display("FAIL bp_correct: got %0d expected 0", correct_cnt); end
    cmp_cnt++; if (exp_q.size() !== 0) begin err_cnt++; $display("FAIL bp_left: got %0d grams missing expected 0", exp_q.size()); end
  endtask

  task automatic test_short();
    int t, base;
    apply_reset();
    gram_ready = 1'b1;
    base = done_cnt;
    send_msg(str2msg("hi"), 2, 2'd1, t);
    repeat (2) tick();
    cmp_cnt++; if (done_cyc !== t + 1) begin err_cnt++; $display("FAIL short2_done_cycle: got %0d expected %0d", done_cyc, t + 1); end
    cmp_cnt++; if (done_cnt - base !== 1) begin err_cnt++; $display("FAIL short2_pulses: got %0d expected 1", done_cnt - base); end
    send_msg(str2msg(""), 0, 2'd2, t);
    repeat (3) tick();
    cmp_cnt++; if (done_cyc !== t + 1) begin err_cnt++; $display("FAIL short0_done_cycle: got %0d expected %0d", done_cyc, t + 1); end
    cmp_cnt++; if (done_cnt - base !== 2) begin err_cnt++; $display("FAIL short0_pulses: got %0d expected 2", done_cnt - base); end
    cmp_cnt++; if (gv_cnt !== 0) begin err_cnt++; $display("FAIL short_no_grams: got %0d valid cycles expected 0", gv_cnt); end
    cmp_cnt++; if (total_cnt !== 3'd0 || correct_cnt !== 3'd0) begin err_cnt++; $display("FAIL short_counters: got %0d/%0d expected 0/0", total_cnt, correct_cnt); end
  endtask

  task automatic test_clamp();
    logic [MAX_LENGTH*8-1:0] m;
    word_t exp_last;
    int t, tc, base;
    bit ok1, ok2;
    apply_reset();
    gram_ready = 1'b1;
    for (int i = 0; i < MAX_LENGTH; i++) m[i*8 +: 8] = 8'(i * 7 + 3);
    exp_last = {1'b1, 8'(197 * 7 + 3), 8'(198 * 7 + 3), 8'(199 * 7 + 3)};
    base = done_cnt;
    send_msg(m, 250, 2'd0, t);
    wait_last(ok1);
    tick();
    pulse_class(2'd0, tc);
    wait_done(base, ok2);
    tick();
    cmp_cnt++; if (!ok1 || !ok2) begin err_cnt++; $display("FAIL clamp_timeout: got last=%b done=%b expected 1 1", ok1, ok2); end
    cmp_cnt++; if (xfer_cnt !== 198) begin err_cnt++; $display("FAIL clamp_xfers: got %0d expected 198", xfer_cnt); end
    cmp_cnt++; if (last_word !== exp_last) begin err_cnt++; $display("FAIL clamp_last_gram: got %h expected %h", last_word, exp_last); end
    cmp_cnt++; if (total_cnt !== 3'd1 || correct_cnt !== 3'd1) begin err_cnt++; $display("FAIL clamp_counters: got %0d/%0d expected 1/1", total_cnt, correct_cnt); end
    cmp_cnt++; if (exp_q.size() !== 0) begin err_cnt++; $display("FAIL clamp_left: got %0d grams missing expected 0", exp_q.size()); end
  endtask

  task automatic test_ignored();
    int t, tc, base;
    bit ok1, ok2, ok3;
    apply_reset();
    gram_ready = 1'b1;
    base = done_cnt;
    send_msg(str2msg("abcdefgh"), 8, 2'd1, t);
    wait_gv(ok1);
    tick();
    msg         = str2msg("zzzzzzzz");
    length      = 8'd4;
    label       = 2'd2;
    msg_valid   = 1'b1;
    class_valid = 1'b1;
    class_label = 2'd1;
    tick();
    msg_valid   = 1'b0;
    class_valid = 1'b0;
    cmp_cnt++; if (total_cnt !== 3'd0) begin err_cnt++; $display("FAIL ign_class_mid_stream: got total %0d expected 0", total_cnt); end
    wait_last(ok2);
    tick();
    pulse_class(2'd2, tc);
    wait_done(base, ok3);
    tick();
    cmp_cnt++; if (!ok1 || !ok2 || !ok3) begin err_cnt++; $display("FAIL ign_timeout: got %b%b%b expected 111", ok1, ok2, ok3); end
    cmp_cnt++; if (xfer_cnt !== 6) begin err_cnt++; $display("FAIL ign_xfers: got %0d expected 6", xfer_cnt); end
    cmp_cnt++; if (total_cnt !== 3'd1 || correct_cnt !== 3'd0) begin err_cnt++; $display("FAIL ign_counters: got %0d/%0d expected 1/0", total_cnt, correct_cnt); end
    cmp_cnt++; if (exp_q.size() !== 0) begin err_cnt++; $display("FAIL ign_left: got %0d grams missing expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int t, tc, base;
    bit ok1, ok2, ok3;
    gram_ready = 1'b1;
    send_msg(str2msg("hello"), 5, 2'd1, t);
    wait_gv(ok1);
    tick();
    base = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp_cnt++; if (gram_valid !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL rmid_state: got valid=%b busy=%b expected 0 0", gram_valid, busy); end
    cmp_cnt++; if (total_cnt !== 3'd0 || correct_cnt !== 3'd0) begin err_cnt++; $display("FAIL rmid_counters: got %0d/%0d expected 0/0", total_cnt, correct_cnt); end
    clear_stats();
    repeat (5) tick();
    cmp_cnt++; if (done_cnt !== base) begin err_cnt++; $display("FAIL rmid_no_done: got %0d pulses expected 0", done_cnt - base); end
    send_msg(str2msg("world"), 5, 2'd3, t);
    wait_last(ok2);
    tick();
    pulse_class(2'd3, tc);
    wait_done(base, ok3);
    tick();
    cmp_cnt++; if (!ok1 || !ok2 || !ok3) begin err_cnt++; $display("FAIL rmid_timeout: got %b%b%b expected 111", ok1, ok2, ok3); end
    cmp_cnt++; if (first_xfer_cyc !== t + 4) begin err_cnt++; $display("FAIL rmid_latency: got cycle %0d expected %0d", first_xfer_cyc, t + 4); end
    cmp_cnt++; if (xfer_cnt !== 3) begin err_cnt++; $display("FAIL rmid_xfers: got %0d expected 3", xfer_cnt); end
    cmp_cnt++; if (total_cnt !== 3'd1 || correct_cnt !== 3'd1) begin err_cnt++; $display("FAIL rmid_counters_after: got %0d/%0d expected 1/1", total_cnt, correct_cnt); end
  endtask

  task automatic test_saturation();
    int t, tc, base;
    bit ok1, ok2, all_ok;
    apply_reset();
    gram_ready = 1'b1;
    all_ok = 1'b1;
    // Ten messages: the first two misclassified, so both counters pass 2^CNT_W-1.
    for (int n = 0; n < 10; n++) begin
      base = done_cnt;
      send_msg(str2msg("abc"), 3, 2'd1, t);
      wait_last(ok1);
      tick();
      pulse_class((n < 2) ? 2'd0 : 2'd1, tc);
      wait_done(base, ok2);
      tick();
      all_ok = all_ok && ok1 && ok2;
    end
    cmp_cnt++; if (!all_ok) begin err_cnt++; $display("FAIL sat_timeout: got %b expected 1", all_ok); end
    cmp_cnt++; if (total_cnt !== 3'd7) begin err_cnt++; $display("FAIL sat_total: got %0d expected 7", total_cnt); end
    cmp_cnt++; if (correct_cnt !== 3'd7) begin err_cnt++; $display("FAIL sat_correct: got %0d expected 7", correct_cnt); end
    cmp_cnt++; if (xfer_cnt !== 10) begin err_cnt++; $display("FAIL sat_xfers: got %0d expected 10", xfer_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_short();
    test_clamp();
    test_ignored();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
